// File: rtl/snes_event_queue_pkg.sv
// Shared constants, types and scanner state encodings for the SNES controller event queue.
package snes_event_queue_pkg;

   localparam int unsigned SNES_BUTTON_COUNT = 12;
   localparam int unsigned EVENT_WIDTH       = 5;

   localparam int unsigned BTN_B      = 0;
   localparam int unsigned BTN_Y      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;
   localparam int unsigned BTN_A      = 8;
   localparam int unsigned BTN_X      = 9;
   localparam int unsigned BTN_L      = 10;
   localparam int unsigned BTN_R      = 11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   typedef logic [SNES_BUTTON_COUNT-1:0] btn_vec_t;
   typedef logic [EVENT_WIDTH-1:0]       event_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic logic [3:0] lowest_set(input btn_vec_t v);
      lowest_set = 4'd0;
      for (int i = SNES_BUTTON_COUNT - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = 4'(i);
      end
   endfunction

endpackage

// File: rtl/snes_event_queue_if.sv
// Event stream handshake plus sticky overflow status between the queue and its consumer.
interface snes_event_queue_if;
   import snes_event_queue_pkg::*;

   logic   event_valid;
   logic   event_ready;
   event_t event_data;
   logic   overflow;
   logic   overflow_clear;

   modport master (
      output event_valid, event_data, overflow,
      input  event_ready, overflow_clear
   );

   modport slave (
      input  event_valid, event_data, overflow,
      output event_ready, overflow_clear
   );

endinterface

// File: rtl/snes_event_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module snes_event_fifo #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/snes_event_queue.sv
// Turns SNES button level changes into press/release events, one per cycle in index order.
module snes_event_queue
   import snes_event_queue_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  btn_vec_t            button_state,
   output btn_vec_t            snapshot,
   snes_event_queue_if.master  evt
);

   btn_vec_t   r_in_q;
   btn_vec_t   r_snapshot;
   btn_vec_t   r_pending;
   logic [0:0] r_state;
   logic       r_overflow;

   logic [3:0] w_idx;
   btn_vec_t   w_pending_nxt;
   logic       w_push;
   event_t     w_push_data;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   event_t     w_head;
   logic       w_drop;

   assign w_idx         = lowest_set(r_pending);
   assign w_pending_nxt = r_pending & ~(btn_vec_t'(1) << w_idx);
   assign w_push        = (r_state == ST_SCAN);
   assign w_push_data   = {r_snapshot[w_idx], w_idx};
   assign w_pop         = evt.event_valid & evt.event_ready;
   assign w_drop        = w_push & w_full & ~w_pop;

   // Changes arriving while scanning wait in r_in_q; IDLE reports the net change later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_in_q     <= '0;
         r_snapshot <= '0;
         r_pending  <= '0;
         r_state    <= ST_IDLE;
      end else begin
         r_in_q <= button_state;
         case (r_state)
            ST_IDLE: begin
               if (r_in_q != r_snapshot) begin
                  r_pending  <= r_in_q ^ r_snapshot;
                  r_snapshot <= r_in_q;
                  r_state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               r_pending <= w_pending_nxt;
               if (w_pending_nxt == '0) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (evt.overflow_clear) begin
         r_overflow <= 1'b0;
      end
   end

   snes_event_fifo #(
      .WIDTH (EVENT_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   assign evt.event_valid = ~w_empty;
   assign evt.event_data  = w_head;
   assign evt.overflow    = r_overflow;
   assign snapshot        = r_snapshot;

endmodule

// File: tb/tb_snes_event_queue.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random vs. queue model.
module tb_snes_event_queue;

   localparam int unsigned DEPTH = 8;

   logic        clk;
   logic        reset_n;
   logic [11:0] button_state;
   logic [11:0] snapshot;

   int n_vec;
   int n_bad;

   snes_event_queue_if evt_if ();

   snes_event_queue #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .button_state (button_state),
      .snapshot     (snapshot),
      .evt          (evt_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] bs;
      logic        exp_valid;
      logic [4:0]  exp_data;
      logic [11:0] exp_snap;
   } vec_t;

   vec_t vt [17];

   // Reference model: pending events and FIFO contents kept as plain queues.
   logic [11:0] m_in;
   logic [11:0] m_snap;
   logic        m_ovf;
   logic [4:0]  m_scan [$];
   logic [4:0]  m_fifo [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in   = '0;
      m_snap = '0;
      m_ovf  = 1'b0;
      m_scan.delete();
      m_fifo.delete();
   endtask

   task automatic model_step(input logic [11:0] bs, input logic rdy, input logic clr);
      logic       pop;
      logic       have_push;
      logic       drop;
      logic [4:0] ev;
      pop       = (m_fifo.size() != 0) && rdy;
      have_push = 1'b0;
      ev        = '0;
      if (m_scan.size() != 0) begin
         ev        = m_scan.pop_front();
         have_push = 1'b1;
      end else if (m_in != m_snap) begin
         for (int i = 0; i < 12; i++) begin
            if (m_in[i] != m_snap[i]) m_scan.push_back({m_in[i], 4'(i)});
         end
         m_snap = m_in;
      end
      drop = have_push && (m_fifo.size() == DEPTH) && !pop;
      if (pop) void'(m_fifo.pop_front());
      if (have_push && !drop) m_fifo.push_back(ev);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_in = bs;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check({tag, "_rst_valid"}, 32'(evt_if.event_valid), 32'd0);
      check({tag, "_rst_data"},  32'(evt_if.event_data),  32'd0);
      check({tag, "_rst_ovf"},   32'(evt_if.overflow),    32'd0);
      check({tag, "_rst_snap"},  32'(snapshot),           32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Records one event per cycle while ready is held high.
   task automatic collect(input int cycles, input int chg_cycle, input logic [11:0] chg_bs,
                          output logic [4:0] got [$]);
      got.delete();
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (evt_if.event_valid) got.push_back(evt_if.event_data);
         @(negedge clk);
         if (c == chg_cycle) button_state = chg_bs;
      end
   endtask

   initial begin
      logic [4:0]  got [$];
      logic [4:0]  exp_q [$];
      logic [11:0] bs;
      logic        rdy;
      logic        clr;

      n_vec = 0;
      n_bad = 0;
      reset_n = 1'b1;
      button_state = '0;
      evt_if.event_ready = 1'b1;
      evt_if.overflow_clear = 1'b0;

      vt[0]  = '{12'h001, 1'b0, 5'h00, 12'h000};
      vt[1]  = '{12'h001, 1'b0, 5'h00, 12'h001};
      vt[2]  = '{12'h001, 1'b1, 5'h10, 12'h001};
      vt[3]  = '{12'h001, 1'b0, 5'h00, 12'h001};
      vt[4]  = '{12'h001, 1'b0, 5'h00, 12'h001};
      vt[5]  = '{12'h000, 1'b0, 5'h00, 12'h001};
      vt[6]  = '{12'h000, 1'b0, 5'h00, 12'h000};
      vt[7]  = '{12'h000, 1'b1, 5'h00, 12'h000};
      vt[8]  = '{12'h810, 1'b0, 5'h00, 12'h000};
      vt[9]  = '{12'h810, 1'b0, 5'h00, 12'h810};
      vt[10] = '{12'h810, 1'b1, 5'h14, 12'h810};
      vt[11] = '{12'h810, 1'b1, 5'h1B, 12'h810};
      vt[12] = '{12'h810, 1'b0, 5'h00, 12'h810};
      vt[13] = '{12'h800, 1'b0, 5'h00, 12'h810};
      vt[14] = '{12'h800, 1'b0, 5'h00, 12'h800};
      vt[15] = '{12'h800, 1'b1, 5'h04, 12'h800};
      vt[16] = '{12'h800, 1'b0, 5'h00, 12'h800};

      // Single press, two-bit press, single release, one table row per clock.
      do_reset("init");
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         button_state = vt[i].bs;
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_valid", i), 32'(evt_if.event_valid), 32'(vt[i].exp_valid));
         if (vt[i].exp_valid)
            check($sformatf("tbl%0d_data", i), 32'(evt_if.event_data), 32'(vt[i].exp_data));
         check($sformatf("tbl%0d_snap", i), 32'(snapshot), 32'(vt[i].exp_snap));
         check($sformatf("tbl%0d_ovf", i), 32'(evt_if.overflow), 32'd0);
      end

      // All buttons pressed with consumer stalled: FIFO fills, excess dropped.
      button_state = '0;
      evt_if.event_ready = 1'b0;
      do_reset("ovf");
      @(negedge clk);
      button_state = 12'hFFF;
      repeat (16) @(posedge clk);
      @(negedge clk);
      check("ovf_set", 32'(evt_if.overflow), 32'd1);
      check("ovf_snap", 32'(snapshot), 32'hFFF);
      evt_if.event_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d_valid", i), 32'(evt_if.event_valid), 32'd1);
         check($sformatf("drain%0d_data", i), 32'(evt_if.event_data), 32'({1'b1, 4'(i)}));
         @(negedge clk);
      end
      check("drain_empty", 32'(evt_if.event_valid), 32'd0);
      check("ovf_sticky", 32'(evt_if.overflow), 32'd1);
      evt_if.overflow_clear = 1'b1;
      @(negedge clk);
      evt_if.overflow_clear = 1'b0;
      check("ovf_cleared", 32'(evt_if.overflow), 32'd0);

      // Buttons released again during the scan: net change reported afterwards.
      button_state = '0;
      do_reset("mid");
      @(negedge clk);
      button_state = 12'h003;
      collect(12, 1, 12'h000, got);
      exp_q = '{5'h10, 5'h11, 5'h00, 5'h01};
      check("mid_count", 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("mid_ev%0d", i), 32'(got[i]), 32'(exp_q[i]));

      // Reset in the middle of a scan with buttons held.
      button_state = '0;
      do_reset("scan");
      evt_if.event_ready = 1'b0;
      @(negedge clk);
      button_state = 12'h00F;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("prereset_valid", 32'(evt_if.event_valid), 32'd1);
      do_reset("midscan");
      evt_if.event_ready = 1'b1;
      collect(12, -1, 12'h000, got);
      exp_q = '{5'h10, 5'h11, 5'h12, 5'h13};
      check("held_count", 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("held_ev%0d", i), 32'(got[i]), 32'(exp_q[i]));

      // Random stimulus against the queue model, alternating fast and slow consumers.
      button_state = '0;
      do_reset("rand");
      model_reset();
      bs = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 9) == 0) bs = 12'($urandom);
            else bs = bs ^ (12'($urandom) & 12'($urandom) & 12'($urandom));
         end
         if (((c / 150) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
         else rdy = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 31) == 0);
         button_state = bs;
         evt_if.event_ready = rdy;
         evt_if.overflow_clear = clr;
         @(posedge clk);
         model_step(bs, rdy, clr);
         #1;
         check("rnd_valid", 32'(evt_if.event_valid), 32'(m_fifo.size() != 0));
         check("rnd_data", 32'(evt_if.event_data), 32'((m_fifo.size() != 0) ? m_fifo[0] : 5'h00));
         check("rnd_ovf", 32'(evt_if.overflow), 32'(m_ovf));
         check("rnd_snap", 32'(snapshot), 32'(m_snap));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
